// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Iterative restoring divider for UDIV/SDIV, one quotient bit per
//            clock, with sign pre/post-correction for signed operands.
// Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              c_cw       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cw-1:0] c_cnt_init = c_cw'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_dvd;
    logic [WIDTH-1:0]  r_rem;
    logic [WIDTH-1:0]  r_dsr;
    logic [c_cw-1:0]   r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [WIDTH-1:0]  r_quotient;
    logic [WIDTH-1:0]  r_remainder;
    logic              r_div_by_zero;

    logic              w_launch;
    logic              w_dsr_zero;
    logic              w_dvd_neg;
    logic              w_dsr_neg;
    logic [WIDTH-1:0]  w_dvd_abs;
    logic [WIDTH-1:0]  w_dsr_abs;
    logic [WIDTH:0]    w_trial;
    logic [WIDTH:0]    w_diff;
    logic              w_qbit;

    assign w_launch   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_dsr_zero = (divisor == '0);
    assign w_dvd_neg  = is_signed && dividend[WIDTH-1];
    assign w_dsr_neg  = is_signed && divisor[WIDTH-1];
    // -(most negative) wraps to itself, which is the correct unsigned magnitude
    assign w_dvd_abs  = w_dvd_neg ? -dividend : dividend;
    assign w_dsr_abs  = w_dsr_neg ? -divisor  : divisor;

    // Top bit of the difference is the borrow: clear means the subtract fits
    assign w_trial = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_dsr};
    assign w_qbit  = ~w_diff[WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_launch) begin
                    w_state_next = w_dsr_zero ? S_DONE : S_CALC;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX:   w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dvd         <= '0;
            r_rem         <= '0;
            r_dsr         <= '0;
            r_cnt         <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_launch) begin
                        if (w_dsr_zero) begin
                            // Non-trapping divide by zero: result is immediate
                            r_quotient    <= '0;
                            r_remainder   <= dividend;
                            r_div_by_zero <= 1'b1;
                        end else begin
                            r_dvd         <= w_dvd_abs;
                            r_dsr         <= w_dsr_abs;
                            r_rem         <= '0;
                            r_cnt         <= c_cnt_init;
                            r_neg_q       <= w_dvd_neg ^ w_dsr_neg;
                            r_neg_r       <= w_dvd_neg;
                            r_div_by_zero <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cw'(1);
                    end
                end
                S_FIX: begin
                    // Truncation toward zero; remainder follows the dividend's sign
                    r_quotient  <= r_neg_q ? -r_dvd : r_dvd;
                    r_remainder <= r_neg_r ? -r_rem : r_rem;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == S_CALC) || (r_state == S_FIX);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire
